// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the Beta fetch stage: vectors, NOP encoding,
// next-PC select codes, fetch FSM states and the IF/ID register layout.
package beta_pkg;

    // ADD(R31, R31, R31): architecturally a no-op.
    localparam logic [31:0] NOP       = 32'h83FF_F800;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADDR_VEC = 32'h8000_0008;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_HOLD,
        NPC_REDIR,
        NPC_TRAP,
        NPC_IRQ
    } npc_sel_e;

    typedef enum logic {
        RST_FILL,
        RUN
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP, pc_plus4: 32'h0};

    // Bit 31 is the supervisor flag; the increment wraps within 30:0 and never carries into it.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory, control and IF/ID signals.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if;
    logic [31:0] ia;
    logic [31:0] id;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illop;
    logic        irq;
    logic        irq_ack;
    logic [31:0] irq_xp;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;

    modport master (
        output ia, irq_ack, irq_xp, if_valid, if_instr, if_pc_plus4,
        input  id, stall, redirect_valid, redirect_pc, illop, irq
    );

    modport slave (
        input  ia, irq_ack, irq_xp, if_valid, if_instr, if_pc_plus4,
        output id, stall, redirect_valid, redirect_pc, illop, irq
    );
endinterface

// File: rtl/fetch_stage_npc.sv
// fetch_npc: combinational next-PC priority select with supervisor-bit masking.
// Interrupt acceptance exists only when BETA_IRQ_EN is defined.
module fetch_npc
    import beta_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        illop,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        irq,
    input  logic        stall,
    input  logic        irq_block,
    output logic [31:0] npc,
    output npc_sel_e    sel
);

    logic irq_take;

`ifdef BETA_IRQ_EN
    // Only user-mode code is interruptible, and never while decode is stalled.
    assign irq_take = irq && !pc[31] && !stall && !irq_block;
`else
    logic unused_irq;
    assign unused_irq = irq ^ irq_block;
    assign irq_take   = 1'b0;
`endif

    always_comb begin
        sel = NPC_SEQ;
        npc = pc_inc(pc);
        if (illop) begin
            sel = NPC_TRAP;
            npc = ILLOP_VEC;
        end else if (redirect_valid) begin
            // A redirect may drop to user mode but can never enter supervisor mode.
            sel = NPC_REDIR;
            npc = {pc[31] & redirect_pc[31], redirect_pc[30:2], 2'b00};
        end else if (irq_take) begin
            sel = NPC_IRQ;
            npc = XADDR_VEC;
        end else if (stall) begin
            sel = NPC_HOLD;
            npc = pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Beta instruction-fetch stage: PC register, IF/ID register and reset-fill FSM.
// Define BETA_IRQ_EN to include interrupt acceptance (irq_ack / irq_xp).
module fetch_stage
    import beta_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    fetch_stage_if.master fif
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    ifid_t        ifid_reg, ifid_next;

    logic [31:0]  npc;
    npc_sel_e     npc_sel;

    fetch_npc u_npc (
        .pc             (pc_reg),
        .illop          (fif.illop),
        .redirect_valid (fif.redirect_valid),
        .redirect_pc    (fif.redirect_pc),
        .irq            (fif.irq),
        .stall          (fif.stall),
        .irq_block      (state_reg == RST_FILL),
        .npc            (npc),
        .sel            (npc_sel)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RST_FILL: state_next = RUN;
            RUN:      state_next = RUN;
        endcase
    end

    always_comb begin
        pc_next   = npc;
        ifid_next = ifid_reg;
        case (npc_sel)
            NPC_SEQ:  ifid_next = '{valid: 1'b1, instr: fif.id, pc_plus4: pc_inc(pc_reg)};
            NPC_HOLD: ifid_next = ifid_reg;
            default:  ifid_next = IFID_BUBBLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= RST_FILL;
            pc_reg    <= RESET_VEC;
            ifid_reg  <= IFID_BUBBLE;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ifid_reg  <= ifid_next;
        end
    end

`ifdef BETA_IRQ_EN
    logic        irq_ack_reg, irq_ack_next;
    logic [31:0] irq_xp_reg, irq_xp_next;

    // pc_reg[31] is clear whenever an interrupt is taken, so pc_inc yields a user-mode return address.
    always_comb begin
        irq_ack_next = (npc_sel == NPC_IRQ);
        irq_xp_next  = (npc_sel == NPC_IRQ) ? pc_inc(pc_reg) : irq_xp_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_ack_reg <= 1'b0;
            irq_xp_reg  <= 32'h0;
        end else begin
            irq_ack_reg <= irq_ack_next;
            irq_xp_reg  <= irq_xp_next;
        end
    end

    assign fif.irq_ack = irq_ack_reg;
    assign fif.irq_xp  = irq_xp_reg;
`else
    assign fif.irq_ack = 1'b0;
    assign fif.irq_xp  = 32'h0;
`endif

    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^fif.redirect_pc[1:0];

    assign fif.ia          = pc_reg;
    assign fif.if_valid    = ifid_reg.valid;
    assign fif.if_instr    = ifid_reg.instr;
    assign fif.if_pc_plus4 = ifid_reg.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns ~address so each
// fetched word is easy to predict by hand.
module tb_fetch_stage;
    import beta_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    fetch_stage_if fif ();

    fetch_stage u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .fif     (fif)
    );

    always #5 clk = ~clk;

    assign fif.id = ~fif.ia;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] p4);
        chk({tag, ".valid"}, {31'h0, fif.if_valid}, {31'h0, v});
        chk({tag, ".instr"}, fif.if_instr, instr);
        chk({tag, ".pc4"}, fif.if_pc_plus4, p4);
    endtask

    initial begin
        reset_n            = 1'b0;
        fif.stall          = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = 32'h0;
        fif.illop          = 1'b0;
        fif.irq            = 1'b0;
        step();
        step();

        // Reset state
        chk("rst.ia", fif.ia, 32'h8000_0000);
        chk_ifid("rst", 1'b0, 32'h83FF_F800, 32'h0);
        chk("rst.ack", {31'h0, fif.irq_ack}, 32'h0);
        chk("rst.xp", fif.irq_xp, 32'h0);

        // Free run from the reset vector
        reset_n = 1'b1;
        chk("run0.ia", fif.ia, 32'h8000_0000);
        step();
        chk("run1.ia", fif.ia, 32'h8000_0004);
        chk_ifid("run1", 1'b1, 32'h7FFF_FFFF, 32'h8000_0004);
        step();
        chk("run2.ia", fif.ia, 32'h8000_0008);
        step();
        chk("run3.ia", fif.ia, 32'h8000_000C);
        chk_ifid("run3", 1'b1, 32'h7FFF_FFF7, 32'h8000_000C);

        // Redirect to user code; low target bits ignored
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h0000_0103;
        step();
        chk("redir1.ia", fif.ia, 32'h0000_0100);
        chk_ifid("redir1", 1'b0, 32'h83FF_F800, 32'h0);

        // Redirect from user mode cannot set bit 31
        fif.redirect_pc = 32'h8000_0200;
        step();
        chk("redir2.ia", fif.ia, 32'h0000_0200);
        chk_ifid("redir2", 1'b0, 32'h83FF_F800, 32'h0);
        fif.redirect_valid = 1'b0;
        step();
        chk("redir3.ia", fif.ia, 32'h0000_0204);
        chk_ifid("redir3", 1'b1, 32'hFFFF_FDFF, 32'h0000_0204);

        // Stall at PC=0x40
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h0000_003C;
        step();
        fif.redirect_valid = 1'b0;
        step();
        chk("pre_stall.ia", fif.ia, 32'h0000_0040);
        fif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.ia", fif.ia, 32'h0000_0040);
            chk_ifid("stall", 1'b1, 32'hFFFF_FFC3, 32'h0000_0040);
        end
        fif.illop = 1'b1;
        step();
        chk("illop.ia", fif.ia, 32'h8000_0004);
        chk_ifid("illop", 1'b0, 32'h83FF_F800, 32'h0);
        fif.illop = 1'b0;
        fif.stall = 1'b0;
        step();
        chk("post_trap.ia", fif.ia, 32'h8000_0008);
        chk_ifid("post_trap", 1'b1, 32'h7FFF_FFFB, 32'h8000_0008);

        // Interrupt from user mode at PC=0x80
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h0000_0080;
        step();
        fif.redirect_valid = 1'b0;
        chk("irq0.ia", fif.ia, 32'h0000_0080);
        fif.irq = 1'b1;
        step();
`ifdef BETA_IRQ_EN
        chk("irq1.ia", fif.ia, 32'h8000_0008);
        chk("irq1.ack", {31'h0, fif.irq_ack}, 32'h1);
        chk("irq1.xp", fif.irq_xp, 32'h0000_0084);
        chk_ifid("irq1", 1'b0, 32'h83FF_F800, 32'h0);
        step();
        chk("irq2.ia", fif.ia, 32'h8000_000C);
        chk("irq2.ack", {31'h0, fif.irq_ack}, 32'h0);
        step();
        chk("irq3.ia", fif.ia, 32'h8000_0010);
        chk("irq3.ack", {31'h0, fif.irq_ack}, 32'h0);
`else
        chk("irq1.ia", fif.ia, 32'h0000_0084);
        chk("irq1.ack", {31'h0, fif.irq_ack}, 32'h0);
        chk("irq1.xp", fif.irq_xp, 32'h0);
        chk_ifid("irq1", 1'b1, 32'hFFFF_FF7F, 32'h0000_0084);
        step();
        chk("irq2.ia", fif.ia, 32'h0000_0088);
        chk("irq2.ack", {31'h0, fif.irq_ack}, 32'h0);
        step();
        chk("irq3.ia", fif.ia, 32'h0000_008C);
        chk("irq3.ack", {31'h0, fif.irq_ack}, 32'h0);
`endif
        // Pending irq with a redirect back to user mode: redirect wins, then irq
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h0000_0100;
        step();
        chk("pend0.ia", fif.ia, 32'h0000_0100);
        chk("pend0.ack", {31'h0, fif.irq_ack}, 32'h0);
        fif.redirect_valid = 1'b0;
        step();
`ifdef BETA_IRQ_EN
        chk("pend1.ia", fif.ia, 32'h8000_0008);
        chk("pend1.ack", {31'h0, fif.irq_ack}, 32'h1);
        chk("pend1.xp", fif.irq_xp, 32'h0000_0104);
`else
        chk("pend1.ia", fif.ia, 32'h0000_0104);
        chk("pend1.ack", {31'h0, fif.irq_ack}, 32'h0);
`endif
        fif.irq = 1'b0;

        // Increment wrap keeps bit 31
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h7FFF_FFFC;
        step();
        fif.redirect_valid = 1'b0;
        chk("wrap0.ia", fif.ia, 32'h7FFF_FFFC);
        step();
        chk("wrap1.ia", fif.ia, 32'h0000_0000);
        chk_ifid("wrap1", 1'b1, 32'h8000_0003, 32'h0000_0000);
        fif.illop = 1'b1;
        step();
        fif.illop          = 1'b0;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'hFFFF_FFFC;
        step();
        fif.redirect_valid = 1'b0;
        chk("wrap2.ia", fif.ia, 32'hFFFF_FFFC);
        step();
        chk("wrap3.ia", fif.ia, 32'h8000_0000);
        chk_ifid("wrap3", 1'b1, 32'h0000_0003, 32'h8000_0000);

        // Reset mid-stream overrides redirect and irq
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h0000_0300;
        fif.irq            = 1'b1;
        reset_n            = 1'b0;
        step();
        chk("mrst.ia", fif.ia, 32'h8000_0000);
        chk_ifid("mrst", 1'b0, 32'h83FF_F800, 32'h0);
        chk("mrst.ack", {31'h0, fif.irq_ack}, 32'h0);
        chk("mrst.xp", fif.irq_xp, 32'h0);
        fif.redirect_valid = 1'b0;
        fif.irq            = 1'b0;
        reset_n            = 1'b1;
        step();
        chk("mrst1.ia", fif.ia, 32'h8000_0004);
        chk_ifid("mrst1", 1'b1, 32'h7FFF_FFFF, 32'h8000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
